// File: rtl/noc_packetizer_pkg.sv
// noc_packetizer_pkg: NoC flit, head and descriptor types shared by the packetizer and router
package noc_packetizer_pkg;
  localparam int VC_NUM = 2;
  localparam int VC_SIZE = VC_NUM > 1 ? $clog2(VC_NUM) : 1;
  localparam int ADDR_NETWORK = 2;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int FLIT_DATA_SIZE = 32;
  localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - ADDR_NETWORK - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
  localparam int MAX_PKT_BODY = 8;
  localparam int PKT_LEN_W = $clog2(MAX_PKT_BODY + 1);
  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;
  typedef struct packed {
    logic [ADDR_NETWORK-1:0]      sub_network;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;
  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;
  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
  typedef struct packed {
    logic [ADDR_NETWORK-1:0]      sub_network;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    logic [PKT_LEN_W-1:0]         len;
  } pkt_desc_t;
  typedef enum logic [1:0] {ST_IDLE, ST_VCSEL, ST_BODY} pkt_state_t;
endpackage

// File: rtl/rr_vc_picker.sv
// rr_vc_picker: combinational round-robin pick of the first request after the pointer
// Ports:
//   i_req  - one request bit per VC
//   i_ptr  - last granted index; scanning starts at i_ptr+1 (mod N)
//   o_gnt  - high when any request was picked
//   o_idx  - index of the picked request
module rr_vc_picker
  import noc_packetizer_pkg::*;
#(
  parameter int N = VC_NUM,
  parameter int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_k;
  always_comb begin
    o_gnt = 1'b0;
    o_idx = '0;
    w_k = '0;
    for (int i = 1; i <= N; i++) begin
      w_k = IW'((int'(i_ptr) + i) % N);
      if (!o_gnt && i_req[w_k]) begin
        o_gnt = 1'b1;
        o_idx = w_k;
      end
    end
  end
endmodule

// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a packet descriptor plus body words into labelled flits on one VC
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   pkt_valid_i / pkt_ready_o  - descriptor handshake (sub-network, x/y dest, head payload, len)
//   body_valid_i / body_ready_o, body_data_i - body word handshake
//   flit_o, flit_valid_o       - registered flit towards the router LOCAL port
//   on_off_i, allocatable_i    - per-VC router backpressure and VC-free flags
module noc_packetizer
  import noc_packetizer_pkg::*;
#(
  parameter int MAX_BODY = MAX_PKT_BODY,
  parameter int LEN_W = $clog2(MAX_BODY + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pkt_valid_i,
  output logic                         pkt_ready_o,
  input  logic [ADDR_NETWORK-1:0]      pkt_sub_network_i,
  input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [LEN_W-1:0]             pkt_len_i,
  input  logic                         body_valid_i,
  output logic                         body_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]    body_data_i,
  output flit_t                        flit_o,
  output logic                         flit_valid_o,
  input  logic [VC_NUM-1:0]            on_off_i,
  input  logic [VC_NUM-1:0]            allocatable_i
);
  pkt_state_t         r_state, w_state_nxt;
  pkt_desc_t          r_desc, w_desc_nxt;
  logic [VC_SIZE-1:0] r_vc, w_vc_nxt;
  logic [VC_SIZE-1:0] r_ptr, w_ptr_nxt;
  flit_t              r_flit, w_flit_nxt;
  logic               r_fv, w_fv_nxt;
  logic               w_pick_gnt;
  logic [VC_SIZE-1:0] w_pick_idx;
  logic [LEN_W-1:0]   w_len_sat;
  assign w_len_sat = pkt_len_i > LEN_W'(MAX_BODY) ? LEN_W'(MAX_BODY) : pkt_len_i;
  rr_vc_picker #(.N(VC_NUM), .IW(VC_SIZE)) u_pick (
    .i_req (allocatable_i & on_off_i),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );
  assign flit_o = r_flit;
  assign flit_valid_o = r_fv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_desc <= '0;
      r_vc <= '0;
      r_ptr <= VC_SIZE'(VC_NUM - 1);
      r_flit <= '0;
      r_fv <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_desc <= w_desc_nxt;
      r_vc <= w_vc_nxt;
      r_ptr <= w_ptr_nxt;
      r_flit <= w_flit_nxt;
      r_fv <= w_fv_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_desc_nxt = r_desc;
    w_vc_nxt = r_vc;
    w_ptr_nxt = r_ptr;
    w_flit_nxt = '0;
    w_fv_nxt = 1'b0;
    pkt_ready_o = rst_n && r_state == ST_IDLE;
    // backpressure on the packet's own VC stalls body acceptance in the same cycle
    body_ready_o = rst_n && r_state == ST_BODY && on_off_i[r_vc];
    case (r_state)
      ST_IDLE: if (pkt_valid_i) begin
        w_desc_nxt = '{sub_network: pkt_sub_network_i, x_dest: pkt_x_dest_i, y_dest: pkt_y_dest_i,
                       head_pl: pkt_head_pl_i, len: PKT_LEN_W'(w_len_sat)};
        w_state_nxt = ST_VCSEL;
      end
      ST_VCSEL: if (w_pick_gnt) begin
        w_vc_nxt = w_pick_idx;
        w_ptr_nxt = w_pick_idx;
        w_flit_nxt.flit_label = r_desc.len == '0 ? HEADTAIL : HEAD;
        w_flit_nxt.vc_id = w_pick_idx;
        w_flit_nxt.data.head_data = '{sub_network: r_desc.sub_network, x_dest: r_desc.x_dest,
                                      y_dest: r_desc.y_dest, head_pl: r_desc.head_pl};
        w_fv_nxt = 1'b1;
        w_state_nxt = r_desc.len == '0 ? ST_IDLE : ST_BODY;
      end
      ST_BODY: if (body_valid_i && body_ready_o) begin
        w_flit_nxt.flit_label = r_desc.len == PKT_LEN_W'(1) ? TAIL : BODY;
        w_flit_nxt.vc_id = r_vc;
        w_flit_nxt.data.bt_pl = body_data_i;
        w_fv_nxt = 1'b1;
        w_desc_nxt.len = r_desc.len - PKT_LEN_W'(1);
        w_state_nxt = r_desc.len == PKT_LEN_W'(1) ? ST_IDLE : ST_BODY;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: scenario tasks checking the packetizer against a queue-based flit model
module tb_noc_packetizer;
  import noc_packetizer_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic pkt_valid_i, pkt_ready_o;
  logic [ADDR_NETWORK-1:0] pkt_sub_network_i;
  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest_i;
  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
  logic [PKT_LEN_W-1:0] pkt_len_i;
  logic body_valid_i, body_ready_o;
  logic [FLIT_DATA_SIZE-1:0] body_data_i;
  flit_t flit_o;
  logic flit_valid_o;
  logic [VC_NUM-1:0] on_off_i, allocatable_i;
  int n_chk = 0, n_fail = 0, cyc = 0, last_vc = VC_NUM - 1;
  flit_t exp_q[$], got_q[$];
  int got_cyc[$];
  logic [FLIT_DATA_SIZE-1:0] bw_q[$];

  noc_packetizer dut (
    .clk(clk), .rst_n(rst_n), .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_sub_network_i(pkt_sub_network_i), .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i),
    .pkt_head_pl_i(pkt_head_pl_i), .pkt_len_i(pkt_len_i), .body_valid_i(body_valid_i),
    .body_ready_o(body_ready_o), .body_data_i(body_data_i), .flit_o(flit_o), .flit_valid_o(flit_valid_o),
    .on_off_i(on_off_i), .allocatable_i(allocatable_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (flit_valid_o) begin
    got_q.push_back(flit_o);
    got_cyc.push_back(cyc);
  end

  function automatic int sat_len(int len);
    return len > MAX_PKT_BODY ? MAX_PKT_BODY : len;
  endfunction

  function automatic int next_vc(logic [VC_NUM-1:0] elig);
    for (int i = 1; i <= VC_NUM; i++)
      if (elig[(last_vc + i) % VC_NUM]) begin
        last_vc = (last_vc + i) % VC_NUM;
        return last_vc;
      end
    return -1;
  endfunction

  function automatic void push_exp(pkt_desc_t d, int vc, int n);
    flit_t f;
    f = '0;
    f.flit_label = n == 0 ? HEADTAIL : HEAD;
    f.vc_id = VC_SIZE'(vc);
    f.data.head_data = '{sub_network: d.sub_network, x_dest: d.x_dest, y_dest: d.y_dest, head_pl: d.head_pl};
    exp_q.push_back(f);
    for (int i = 1; i <= n; i++) begin
      f = '0;
      f.flit_label = i == n ? TAIL : BODY;
      f.vc_id = VC_SIZE'(vc);
      f.data.bt_pl = bw_q[i-1];
      exp_q.push_back(f);
    end
  endfunction

  function automatic pkt_desc_t rand_desc(int len);
    pkt_desc_t d;
    d.sub_network = ADDR_NETWORK'($urandom);
    d.x_dest = DEST_ADDR_SIZE_X'($urandom);
    d.y_dest = DEST_ADDR_SIZE_Y'($urandom);
    d.head_pl = HEAD_PAYLOAD_SIZE'($urandom);
    d.len = PKT_LEN_W'(len);
    return d;
  endfunction

  task automatic clear();
    exp_q = {};
    got_q = {};
    got_cyc = {};
    bw_q = {};
  endtask

  task automatic send_desc(input pkt_desc_t d, output int acc);
    @(negedge clk);
    pkt_valid_i = 1'b1;
    pkt_sub_network_i = d.sub_network;
    pkt_x_dest_i = d.x_dest;
    pkt_y_dest_i = d.y_dest;
    pkt_head_pl_i = d.head_pl;
    pkt_len_i = d.len;
    for (int c = 0; c <= 50; c++) begin
      #1;
      if (pkt_ready_o) break;
      if (c == 50) begin
        n_chk++; n_fail++;
        $display("FAIL desc_accept: pkt_ready_o never rose within 50 cycles");
      end
      @(negedge clk);
    end
    acc = cyc + 1;
    @(negedge clk);
    pkt_valid_i = 1'b0;
  endtask

  task automatic send_body(input int n, input int gap, input int drop_after, input int drop_len, input int vc);
    int k = 0, drops = 0;
    for (int c = 0; k < n; c++) begin
      if (c == 300) begin
        n_chk++; n_fail++;
        $display("FAIL body_timeout: %0d of %0d words accepted", k, n);
        break;
      end
      body_data_i = bw_q[k];
      if (k == drop_after && drops < drop_len) begin
        if (drops > 0) begin
          n_chk++;
          if (flit_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_flit: flit_valid_o=%b required 0", flit_valid_o);
          end
        end
        on_off_i[vc] = 1'b0;
        body_valid_i = 1'b1;
        drops++;
        #1;
        n_chk++;
        if (body_ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_ready: body_ready_o=%b required 0", body_ready_o);
        end
      end else begin
        on_off_i = '1;
        body_valid_i = $urandom_range(99) >= gap;
        #1;
        if (body_valid_i && body_ready_o) k++;
      end
      @(negedge clk);
    end
    body_valid_i = 1'b0;
    on_off_i = '1;
  endtask

  task automatic wait_check(input string name);
    for (int c = 0; got_q.size() < exp_q.size(); c++) begin
      if (c == 100) begin
        n_chk++; n_fail++;
        $display("FAIL %s_timeout: got %0d flits required %0d", name, got_q.size(), exp_q.size());
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d flits required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_flit[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pkt_valid_i = 1'b0;
    body_valid_i = 1'b0;
    body_data_i = '0;
    pkt_sub_network_i = '0; pkt_x_dest_i = '0; pkt_y_dest_i = '0; pkt_head_pl_i = '0; pkt_len_i = '0;
    on_off_i = '1;
    allocatable_i = '1;
    repeat (2) @(negedge clk);
    #1;
    n_chk += 4;
    if (pkt_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_ready: got %b required 0", pkt_ready_o); end
    if (body_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_body_ready: got %b required 0", body_ready_o); end
    if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_flit_valid: got %b required 0", flit_valid_o); end
    if (flit_o !== '0) begin n_fail++; $display("FAIL reset_flit: got %h required 0", flit_o); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (pkt_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_pkt_ready: got %b required 1", pkt_ready_o); end
    last_vc = VC_NUM - 1;
    clear();
  endtask

  task automatic test_headtail();
    pkt_desc_t d;
    int acc, vc;
    d = '{sub_network: 1, x_dest: 3, y_dest: 2, head_pl: 'h1234, len: 0};
    vc = next_vc('1);
    push_exp(d, vc, 0);
    send_desc(d, acc);
    @(negedge clk);
    n_chk += 2;
    if (flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL ht_valid: got %b required 1", flit_valid_o); end
    if (pkt_ready_o !== 1'b1) begin n_fail++; $display("FAIL ht_ready_again: got %b required 1", pkt_ready_o); end
    @(negedge clk);
    n_chk++;
    if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL ht_pulse: got %b required 0", flit_valid_o); end
    wait_check("headtail");
    n_chk++;
    if (got_cyc.size() == 0 || got_cyc[0] != acc + 1)
      begin n_fail++; $display("FAIL ht_latency: got cycle %0d required %0d", got_cyc.size() ? got_cyc[0] : -1, acc + 1); end
    clear();
  endtask

  task automatic test_back_to_back();
    pkt_desc_t d;
    int acc, vc;
    d = '{sub_network: 2, x_dest: 5, y_dest: 6, head_pl: 'h2BEEF, len: 3};
    for (int p = 0; p < 2; p++) begin
      bw_q = {32'h0AAAA, 32'h0BBBB, 32'h0CCCC};
      vc = next_vc('1);
      push_exp(d, vc, 3);
      send_desc(d, acc);
      send_body(3, 0, -1, 0, vc);
      wait_check(p == 0 ? "b2b_first" : "b2b_second");
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (i >= got_cyc.size() || got_cyc[i] != acc + 1 + i)
          begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d required %0d", i, i < got_cyc.size() ? got_cyc[i] : -1, acc + 1 + i); end
      end
      clear();
    end
  endtask

  task automatic test_vcsel_wait();
    pkt_desc_t d;
    int acc, vc;
    d = rand_desc(0);
    allocatable_i = VC_NUM'(1);
    on_off_i = VC_NUM'(2);
    vc = next_vc(VC_NUM'(1));
    push_exp(d, vc, 0);
    send_desc(d, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL vcsel_hold[%0d]: flit_valid_o=%b required 0", i, flit_valid_o); end
    end
    on_off_i = '1;
    @(negedge clk);
    n_chk++;
    if (flit_valid_o !== 1'b1) begin n_fail++; $display("FAIL vcsel_release: flit_valid_o=%b required 1", flit_valid_o); end
    wait_check("vcsel");
    allocatable_i = '1;
    clear();
  endtask

  task automatic test_on_off_gap();
    pkt_desc_t d;
    int acc, vc;
    d = rand_desc(4);
    for (int i = 0; i < 4; i++) bw_q.push_back($urandom);
    vc = next_vc('1);
    push_exp(d, vc, 4);
    send_desc(d, acc);
    send_body(4, 0, 1, 3, vc);
    wait_check("onoff");
    clear();
  endtask

  task automatic test_saturation();
    pkt_desc_t d;
    int acc, vc, n;
    d = rand_desc(15);
    n = sat_len(15);
    for (int i = 0; i < n; i++) bw_q.push_back($urandom);
    vc = next_vc('1);
    push_exp(d, vc, n);
    send_desc(d, acc);
    send_body(n, 0, -1, 0, vc);
    body_valid_i = 1'b1;
    body_data_i = $urandom;
    repeat (3) @(negedge clk);
    body_valid_i = 1'b0;
    wait_check("saturate");
    clear();
  endtask

  task automatic test_reset_mid();
    pkt_desc_t d;
    int acc, vc;
    d = rand_desc(3);
    for (int i = 0; i < 3; i++) bw_q.push_back($urandom);
    vc = next_vc('1);
    push_exp(d, vc, 3);
    exp_q = exp_q[0:0];
    send_desc(d, acc);
    @(negedge clk);
    rst_n = 1'b0;
    body_valid_i = 1'b1;
    body_data_i = bw_q[0];
    #1;
    n_chk += 2;
    if (pkt_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pkt_ready: got %b required 0", pkt_ready_o); end
    if (body_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_body_ready: got %b required 0", body_ready_o); end
    @(negedge clk);
    rst_n = 1'b1;
    body_valid_i = 1'b0;
    n_chk += 2;
    if (flit_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b required 0", flit_valid_o); end
    if (flit_o !== '0) begin n_fail++; $display("FAIL rstmid_flit: got %h required 0", flit_o); end
    wait_check("rstmid");
    clear();
    last_vc = VC_NUM - 1;
    d = rand_desc(1);
    bw_q.push_back($urandom);
    vc = next_vc('1);
    push_exp(d, vc, 1);
    send_desc(d, acc);
    send_body(1, 0, -1, 0, vc);
    wait_check("rstmid_next");
    n_chk++;
    if (got_q.size() == 0 || got_q[0].vc_id !== VC_SIZE'(0))
      begin n_fail++; $display("FAIL rstmid_vc0: got vc %0d required 0", got_q.size() ? int'(got_q[0].vc_id) : -1); end
    clear();
  endtask

  task automatic test_random();
    pkt_desc_t d;
    int acc, vc, n;
    for (int p = 0; p < 20; p++) begin
      d = rand_desc($urandom_range(0, 11));
      n = sat_len(int'(d.len));
      for (int i = 0; i < n; i++) bw_q.push_back($urandom);
      vc = next_vc('1);
      push_exp(d, vc, n);
      send_desc(d, acc);
      send_body(n, 30, -1, 0, vc);
      wait_check("random");
      clear();
    end
  endtask

  initial begin
    test_reset();
    test_headtail();
    test_back_to_back();
    test_vcsel_wait();
    test_on_off_gap();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
